// File: rtl/dcache_line_fill.sv
// Data-cache miss engine: writes back a dirty victim line, fetches the missing
// line word by word over a single-outstanding bus, then commits it in one RAM write.
module dcache_line_fill #(
   parameter int unsigned INDEX_W = 7,
   parameter int unsigned WORDS   = 4,
   localparam int unsigned CNT_W  = $clog2(WORDS),
   localparam int unsigned TAG_W  = 32 - INDEX_W - CNT_W - 2,
   localparam int unsigned LINE_W = 32 * WORDS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               miss_req,
   input  logic [INDEX_W-1:0] miss_index,
   input  logic [TAG_W-1:0]   miss_tag,
   input  logic               victim_dirty,
   input  logic [TAG_W-1:0]   victim_tag,
   input  logic [LINE_W-1:0]  victim_line,
   output logic               mem_req,
   output logic               mem_wr,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic               mem_addr_ok,
   input  logic               mem_data_ok,
   input  logic [31:0]        mem_rdata,
   output logic [INDEX_W-1:0] ram_addr,
   output logic [LINE_W-1:0]  ram_din,
   output logic [1:0]         ram_size,
   output logic               ram_wen,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB_REQ  = 3'd1,
      WB_WAIT = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4,
      FILL    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [INDEX_W-1:0]  idx_q;
   logic [TAG_W-1:0]    mtag_q;
   logic [TAG_W-1:0]    vtag_q;
   logic [LINE_W-1:0]   victim_q;
   logic [LINE_W-1:0]   buf_q;
   logic                last;

   assign last     = (cnt_q == CNT_W'(WORDS - 1));
   assign ram_size = 2'b11;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (miss_req)    state_d = victim_dirty ? WB_REQ : RD_REQ;
         WB_REQ:  if (mem_addr_ok) state_d = WB_WAIT;
         WB_WAIT: if (mem_data_ok) state_d = last ? RD_REQ : WB_REQ;
         RD_REQ:  if (mem_addr_ok) state_d = RD_WAIT;
         RD_WAIT: if (mem_data_ok) state_d = last ? FILL : RD_REQ;
         FILL:                     state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // Miss context, word counter and fill buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         mtag_q   <= '0;
         vtag_q   <= '0;
         victim_q <= '0;
         buf_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (miss_req) begin
               idx_q    <= miss_index;
               mtag_q   <= miss_tag;
               vtag_q   <= victim_tag;
               victim_q <= victim_line;
               cnt_q    <= '0;
            end
            WB_WAIT: if (mem_data_ok) cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
            RD_WAIT: if (mem_data_ok) begin
               buf_q[32 * int'(cnt_q) +: 32] <= mem_rdata;
               if (!last) cnt_q <= cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs are pure decodes of registered state; address and data hold while waiting for acceptance.
   always_comb begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ram_addr  = '0;
      ram_din   = '0;
      ram_wen   = 1'b0;
      done      = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         WB_REQ: begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {vtag_q, idx_q, cnt_q, 2'b00};
            mem_wdata = victim_q[32 * int'(cnt_q) +: 32];
         end
         RD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = {mtag_q, idx_q, cnt_q, 2'b00};
         end
         FILL: begin
            ram_wen  = 1'b1;
            ram_addr = idx_q;
            ram_din  = buf_q;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_line_fill.sv
// Scoreboard bench for dcache_line_fill: a bus responder with configurable stalls,
// an address-keyed memory model, and a monitor checking bus and RAM traffic.
module tb_dcache_line_fill;
   localparam int unsigned INDEX_W = 7;
   localparam int unsigned WORDS   = 4;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned TAG_W   = 21;
   localparam int unsigned LINE_W  = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, miss_req, victim_dirty;
   logic [INDEX_W-1:0] miss_index;
   logic [TAG_W-1:0]   miss_tag, victim_tag;
   logic [LINE_W-1:0]  victim_line;
   logic               mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [31:0]        mem_addr, mem_wdata, mem_rdata;
   logic [INDEX_W-1:0] ram_addr;
   logic [LINE_W-1:0]  ram_din;
   logic [1:0]         ram_size;
   logic               ram_wen, busy, done;

   dcache_line_fill #(.INDEX_W(INDEX_W), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset), .miss_req(miss_req), .miss_index(miss_index),
      .miss_tag(miss_tag), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
      .victim_line(victim_line), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_size(ram_size), .ram_wen(ram_wen), .busy(busy),
      .done(done)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;
   typedef struct {
      logic [INDEX_W-1:0] idx;
      logic [LINE_W-1:0]  line;
   } ram_t;

   bus_t exp_bus[$];
   ram_t exp_ram[$];
   logic [31:0] mem_init [logic [31:0]];

   int n_checks = 0;
   int n_pass   = 0;
   int stall_sum = 0;
   int txn_idx   = 0;
   int bus_mode  = 0;   // 0 zero-wait, 1 random stalls, 2 fixed stall on word 1
   bit hold_req  = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_init.exists(a)) return mem_init[a];
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   // Expected traffic of one miss: optional write-back of all words, then reads, then one line write.
   task automatic push_expect(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] mtag,
                              input bit dirty, input logic [TAG_W-1:0] vtag,
                              input logic [LINE_W-1:0] vline);
      ram_t r;
      bus_t b;
      r.idx = idx;
      r.line = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (dirty) begin
            b.wr = 1'b1;
            b.addr = {vtag, idx, CNT_W'(k), 2'b00};
            b.wdata = vline[32*k +: 32];
            exp_bus.push_back(b);
         end
      end
      for (int k = 0; k < WORDS; k++) begin
         b.wr = 1'b0;
         b.addr = {mtag, idx, CNT_W'(k), 2'b00};
         b.wdata = '0;
         exp_bus.push_back(b);
         r.line[32*k +: 32] = mem_word(b.addr);
      end
      exp_ram.push_back(r);
   endtask

   function automatic int pick_delay(input bit data_phase);
      if (bus_mode == 1) return int'($urandom_range(0, 3));
      if (bus_mode == 2 && txn_idx == 1) return data_phase ? 2 : 3;
      return 0;
   endfunction

   // Bus responder: one transaction at a time, stalls counted into stall_sum.
   bit          pend = 1'b0, counting = 1'b0, pwr = 1'b0;
   logic [31:0] paddr = '0;
   int          await_c = 0, dwait = 0;
   initial begin
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
      forever begin
         @(negedge clk);
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         mem_rdata   = '0;
         if (reset) begin
            pend = 1'b0;
            counting = 1'b0;
            continue;
         end
         if (pend) begin
            if (dwait > 0) begin
               dwait--;
               stall_sum++;
            end else begin
               mem_data_ok = 1'b1;
               if (!pwr) mem_rdata = mem_word(paddr);
               pend = 1'b0;
            end
         end else if (mem_req) begin
            if (!counting) begin
               counting = 1'b1;
               await_c = pick_delay(1'b0);
            end
            if (await_c > 0) begin
               await_c--;
               stall_sum++;
            end else begin
               mem_addr_ok = 1'b1;
               counting = 1'b0;
               pend = 1'b1;
               paddr = mem_addr;
               pwr = mem_wr;
               dwait = pick_delay(1'b1);
               txn_idx++;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on bus acceptance and on RAM writes.
   bit          pend_prev = 1'b0, pw_prev = 1'b0;
   logic [31:0] pa_prev = '0, pd_prev = '0;
   initial begin
      bus_t e;
      ram_t r;
      forever begin
         @(negedge clk);
         #1;
         if (reset) begin
            pend_prev = 1'b0;
            continue;
         end
         if (pend_prev) begin
            check("req_held", mem_req, 1'b1);
            check("addr_stable", mem_addr, pa_prev);
            check("wdata_stable", mem_wdata, pd_prev);
            check("wr_stable", mem_wr, pw_prev);
         end
         if (mem_req && mem_addr_ok) begin
            if (exp_bus.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_bus: got addr %h with nothing expected", mem_addr);
            end else begin
               e = exp_bus.pop_front();
               check("bus_wr", mem_wr, e.wr);
               check("bus_addr", mem_addr, e.addr);
               if (e.wr) check("bus_wdata", mem_wdata, e.wdata);
            end
         end
         pend_prev = mem_req && !mem_addr_ok;
         pa_prev = mem_addr;
         pd_prev = mem_wdata;
         pw_prev = mem_wr;
         if (ram_wen || done) begin
            check("done_with_wen", done, ram_wen);
            if (exp_ram.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_ram_write: got index %h with nothing expected", ram_addr);
            end else begin
               r = exp_ram.pop_front();
               check("ram_addr", ram_addr, r.idx);
               check("ram_din", ram_din, r.line);
               check("ram_size", ram_size, 2'b11);
            end
         end
      end
   end

   // Waits for done from cycle T (inputs applied) and checks the cycle count.
   task automatic wait_done(input bit dirty, input string name);
      int n = 0;
      int exp_n;
      do begin
         @(negedge clk);
         n++;
         miss_req = hold_req;
      end while (!done && n < 400);
      exp_n = 2*WORDS + 1 + (dirty ? 2*WORDS : 0) + stall_sum;
      check(name, n, exp_n);
   endtask

   task automatic do_miss(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] mtag,
                          input bit dirty, input logic [TAG_W-1:0] vtag,
                          input logic [LINE_W-1:0] vline, input string name);
      @(negedge clk);
      miss_req = 1'b1;
      miss_index = idx;
      miss_tag = mtag;
      victim_dirty = dirty;
      victim_tag = vtag;
      victim_line = vline;
      stall_sum = 0;
      txn_idx = 0;
      push_expect(idx, mtag, dirty, vtag, vline);
      wait_done(dirty, name);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req"}, mem_req, 1'b0);
      check({tag, "_mem_wr"}, mem_wr, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      check({tag, "_ram_addr"}, ram_addr, 7'h0);
      check({tag, "_ram_din"}, ram_din, 128'h0);
      check({tag, "_ram_wen"}, ram_wen, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_ram_size"}, ram_size, 2'b11);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LINE_W-1:0] vl;
      reset = 1'b1;
      miss_req = 1'b0;
      miss_index = '0;
      miss_tag = '0;
      victim_dirty = 1'b0;
      victim_tag = '0;
      victim_line = '0;
      for (int k = 0; k < WORDS; k++)
         mem_init[{21'h1ABCD, 7'h15, CNT_W'(k), 2'b00}] = 32'h11 * (k + 1);
      repeat (3) @(negedge clk);
      check_reset_outputs("init");
      reset = 1'b0;

      // Clean miss, zero-wait bus: done at T+9, line 44_33_22_11.
      bus_mode = 0;
      do_miss(7'h15, 21'h1ABCD, 1'b0, 21'h0, '0, "clean_latency");

      // Dirty miss: four write-backs then four reads, done at T+17.
      vl = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      do_miss(7'h2A, 21'h0BEEF, 1'b1, 21'h00001, vl, "dirty_latency");

      // Backpressure on word 1: three cycles without addr_ok, two without data_ok.
      bus_mode = 2;
      do_miss(7'h15, 21'h1ABCD, 1'b0, 21'h0, '0, "backpressure_latency");
      check("backpressure_stalls", stall_sum, 5);
      bus_mode = 0;

      // Reset two cycles in the middle of RD_WAIT abandons the miss.
      @(negedge clk);
      miss_req = 1'b1;
      miss_index = 7'h33;
      miss_tag = 21'h12345;
      victim_dirty = 1'b0;
      push_expect(7'h33, 21'h12345, 1'b0, 21'h0, '0);
      @(negedge clk);
      miss_req = 1'b0;
      @(negedge clk);
      check("rst_busy_before", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst1");
      @(negedge clk);
      check_reset_outputs("rst2");
      reset = 1'b0;
      exp_bus.delete();
      exp_ram.delete();
      do_miss(7'h33, 21'h12345, 1'b0, 21'h0, '0, "after_reset_latency");

      // miss_req held through done: exactly one IDLE cycle, then a second miss.
      hold_req = 1'b1;
      do_miss(7'h05, 21'h0F00D, 1'b0, 21'h0, '0, "hold_first_latency");
      @(negedge clk);
      check("hold_idle_gap", busy, 1'b0);
      stall_sum = 0;
      txn_idx = 0;
      push_expect(7'h05, 21'h0F00D, 1'b0, 21'h0, '0);
      hold_req = 1'b0;
      wait_done(1'b0, "hold_second_latency");

      // Back-to-back clean misses to different indices.
      do_miss(7'h10, 21'h00AAA, 1'b0, 21'h0, '0, "b2b_first_latency");
      do_miss(7'h11, 21'h00BBB, 1'b0, 21'h0, '0, "b2b_second_latency");

      // Random misses with random bus stalls.
      bus_mode = 1;
      for (int i = 0; i < 16; i++) begin
         vl = {$urandom, $urandom, $urandom, $urandom};
         do_miss(INDEX_W'($urandom), TAG_W'($urandom), 1'($urandom),
                 TAG_W'($urandom), vl, "random_latency");
      end
      bus_mode = 0;

      repeat (4) @(negedge clk);
      check("bus_queue_drained", exp_bus.size(), 0);
      check("ram_queue_drained", exp_ram.size(), 0);
      check("final_idle", busy, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
